// File: rtl/spi_slave_if.sv
// spi_slave_if: bundles the serial pins and the host-side tx/rx handshake
// of the SPI target endpoint.
//   sclk, mosi, ss_n   : serial inputs from the SPI master (asynchronous)
//   miso, misoEnable   : serial output and its pad tristate enable
//   txData/txWrite     : host loads the one-entry transmit holding buffer
//   txReady            : holding buffer empty
//   rxData/rxValid     : last complete received word and its unread flag
//   rxRead             : host acknowledges rxData
//   rxOverrun          : one-cycle pulse when an unread word is overwritten
// Modport slave is the endpoint itself; modport master is everything around it.
interface spi_slave_if #(
    parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] txData;
    logic                 txWrite;
    logic                 txReady;
    logic [DATAWIDTH-1:0] rxData;
    logic                 rxValid;
    logic                 rxRead;
    logic                 rxOverrun;
    logic                 sclk;
    logic                 mosi;
    logic                 ss_n;
    logic                 miso;
    logic                 misoEnable;

    modport slave (
        input  txData, txWrite, rxRead, sclk, mosi, ss_n,
        output txReady, rxData, rxValid, rxOverrun, miso, misoEnable
    );

    modport master (
        output txData, txWrite, rxRead, sclk, mosi, ss_n,
        input  txReady, rxData, rxValid, rxOverrun, miso, misoEnable
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI target endpoint. Oversamples sclk/mosi/ss_n with clk,
// deserialises received words and serialises transmit words taken from a
// one-entry holding buffer.
//   clk        : system clock
//   reset      : synchronous, active-high
//   cpol       : sclk idle level, sampled while idle
//   cpha       : 0 sample on leading edge, 1 sample on trailing edge
//   lsbFirst   : 1 shifts bit 0 first, 0 shifts MSB first
//   bus        : serial pins and tx/rx handshake (spi_slave_if.slave)
//
// state  | meaning
// IDLE   | ss_n high (or waiting for a fresh fall); mode inputs tracked
// ACTIVE | frame in progress; shifting on synced sclk edges
module spi_slave #(
    parameter int DATAWIDTH  = 8,
    parameter int SYNCSTAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        lsbFirst,
    spi_slave_if.slave  bus
);
    localparam int CW = $clog2(DATAWIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic [SYNCSTAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                  sclk_prev, ss_prev;
    logic                  cpol_r, cpha_r, lsb_r;
    logic [DATAWIDTH-1:0]  tx_buf, tx_shift, rx_shift, rx_data;
    logic                  tx_ready, rx_valid, rx_overrun;
    logic                  miso_r, miso_en;
    logic                  word_done, need_load;
    logic [CW-1:0]         bit_cnt;

    logic                  sclk_s, mosi_s, ss_s;
    logic                  rise, fall, lead, trail;
    logic                  sample_edge, drive_edge, ss_fall;
    logic [DATAWIDTH-1:0]  next_word, drive_src, rx_next;

    function automatic logic first_bit(input logic [DATAWIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATAWIDTH-1];
    endfunction

    function automatic logic [DATAWIDTH-1:0] shift_out(input logic [DATAWIDTH-1:0] w,
                                                       input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign sclk_s = sclk_sync[SYNCSTAGES-1];
    assign mosi_s = mosi_sync[SYNCSTAGES-1];
    assign ss_s   = ss_sync[SYNCSTAGES-1];

    assign rise        = sclk_s & ~sclk_prev;
    assign fall        = ~sclk_s & sclk_prev;
    assign lead        = cpol_r ? fall : rise;
    assign trail       = cpol_r ? rise : fall;
    assign sample_edge = cpha_r ? trail : lead;
    assign drive_edge  = cpha_r ? lead : trail;
    assign ss_fall     = ss_prev & ~ss_s;

    // An empty holding buffer transmits zeros.
    assign next_word = tx_ready ? '0 : tx_buf;
    // tx_shift always holds the bits not yet presented, so a drive edge
    // presents the head of either the remaining word or a fresh reload.
    assign drive_src = need_load ? next_word : tx_shift;
    assign rx_next   = lsb_r ? {mosi_s, rx_shift[DATAWIDTH-1:1]}
                             : {rx_shift[DATAWIDTH-2:0], mosi_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sclk_sync  <= {SYNCSTAGES{cpol}};
            mosi_sync  <= '0;
            // ss history starts low so a select held low through reset
            // never looks like a fresh falling edge.
            ss_sync    <= '0;
            sclk_prev  <= cpol;
            ss_prev    <= 1'b0;
            cpol_r     <= cpol;
            cpha_r     <= cpha;
            lsb_r      <= lsbFirst;
            tx_buf     <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            tx_ready   <= 1'b1;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            miso_r     <= 1'b0;
            miso_en    <= 1'b0;
            word_done  <= 1'b0;
            need_load  <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNCSTAGES-2:0], bus.sclk};
            mosi_sync <= {mosi_sync[SYNCSTAGES-2:0], bus.mosi};
            ss_sync   <= {ss_sync[SYNCSTAGES-2:0], bus.ss_n};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;

            if (bus.txWrite && tx_ready) begin
                tx_buf   <= bus.txData;
                tx_ready <= 1'b0;
            end

            // A completing word beats a simultaneous rxRead.
            rx_overrun <= 1'b0;
            if (word_done) begin
                rx_data    <= rx_shift;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~bus.rxRead;
            end else if (bus.rxRead) begin
                rx_valid <= 1'b0;
            end
            word_done <= 1'b0;

            case (state)
                IDLE: begin
                    cpol_r <= cpol;
                    cpha_r <= cpha;
                    lsb_r  <= lsbFirst;
                    if (ss_fall) begin
                        state     <= ACTIVE;
                        bit_cnt   <= '0;
                        need_load <= 1'b0;
                        miso_en   <= 1'b1;
                        if (!tx_ready) tx_ready <= 1'b1;
                        if (!cpha) begin
                            miso_r   <= first_bit(next_word, lsbFirst);
                            tx_shift <= shift_out(next_word, lsbFirst);
                        end else begin
                            miso_r   <= 1'b0;
                            tx_shift <= next_word;
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_s) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        need_load <= 1'b0;
                        rx_shift  <= '0;
                        miso_en   <= 1'b0;
                        miso_r    <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == CW'(DATAWIDTH - 1)) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                            need_load <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (drive_edge) begin
                        miso_r   <= first_bit(drive_src, lsb_r);
                        tx_shift <= shift_out(drive_src, lsb_r);
                        if (need_load) begin
                            need_load <= 1'b0;
                            if (!tx_ready) tx_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.txReady    = tx_ready;
    assign bus.rxData     = rx_data;
    assign bus.rxValid    = rx_valid;
    assign bus.rxOverrun  = rx_overrun;
    assign bus.miso       = miso_r;
    assign bus.misoEnable = miso_en;
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI target-side endpoint that sits at the far end of the spi controller's serial link and consumes its sclk/mosi/ss outputs. It produces miso, which feeds the controller's miso input. It oversamples the serial pins with the system clock, deserialises received words, and serialises transmit words from a one-entry holding buffer. It is the standard peripheral-side partner for loopback benches and for on-chip SPI-attached sub-blocks.

Parameters:
DATAWIDTH, 8, bits per SPI word (2..32)
SYNCSTAGES, 2, flop stages on sclk/mosi/ss_n before use (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cpol  input  1  clock idle level (0: sclk idles low)
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
lsbFirst  input  1  1: bit 0 shifted first; 0: MSB first
txData  input  DATAWIDTH  word to return on miso
txWrite  input  1  load txData into holding buffer
txReady  output  1  holding buffer empty
rxData  output  DATAWIDTH  last complete received word
rxValid  output  1  rxData unread
rxRead  input  1  acknowledge rxData, clears rxValid
rxOverrun  output  1  one-cycle pulse: word lost to overwrite
sclk  input  1  serial clock from master (asynchronous)
mosi  input  1  serial data from master (asynchronous)
ss_n  input  1  active-low select (asynchronous)
miso  output  1  serial data to master
misoEnable  output  1  tristate enable for miso pad

Behaviour:
- Interface: one clock clk. reset is synchronous and active-high.
- Reset values: txReady=1, rxValid=0, rxData=0, rxOverrun=0, miso=0, misoEnable=0. Bit counter, shift registers and edge detector are cleared. The sclk history register is loaded with cpol.
- Synchronisation: sclk, mosi and ss_n pass through SYNCSTAGES flops. Edges are detected on the synced sclk against a 1-flop history.
- Timing requirement: sclk high and low phases must each be >= SYNCSTAGES+2 clk cycles. Controller divider 5 satisfies this with SYNCSTAGES=2.
- Edge definitions: leading edge = transition away from cpol. Trailing edge = transition back to cpol.
- Sample edge = leading if cpha=0, trailing if cpha=1. Drive edge = the other edge.
- cpol, cpha and lsbFirst are sampled only in IDLE. Changes during ACTIVE take effect from the next frame.
- State machine IDLE:
  - Synced ss_n falls -> ACTIVE.
  - Word load: if txReady=0, move the holding buffer into the tx shift register and set txReady=1. Otherwise load all zeros.
  - Clear the bit counter.
  - misoEnable=1 from the cycle after the transition.
  - cpha=0: miso presents the first bit in that same cycle.
- State ACTIVE:
  - Sample edge: shift synced mosi into the rx shift register (position chosen by lsbFirst) and increment the bit counter.
  - Drive edge, cpha=0: advance miso to the next bit.
  - Drive edge, cpha=1: the first drive edge presents bit 0 of the word order; later drive edges advance.
  - Word end (counter reaches DATAWIDTH on a sample edge): rxData <= assembled word and rxValid <= 1 on the next clk. Counter resets to 0.
  - Back-to-back words: the next tx word is reloaded (holding buffer if full, else zeros) at the next drive edge. For cpha=1 the reload happens at the next leading edge, so consecutive words need no gap.
  - Synced ss_n rises -> IDLE: the partial word is discarded (no rxValid), the counter is cleared, and misoEnable=0, miso=0 the next cycle.
- rx handshake:
  - rxRead clears rxValid.
  - A word completing while rxValid=1 overwrites rxData, keeps rxValid=1 and pulses rxOverrun for 1 cycle.
  - rxRead in the same cycle as word completion: the new word wins, rxValid stays 1, and there is no overrun.
- tx handshake:
  - txWrite with txReady=1 loads the buffer and txReady falls the next cycle.
  - txWrite with txReady=0 is ignored, including in the same cycle as a buffer-to-shift transfer.
- reset asserted mid-frame: everything returns to reset values immediately. The block re-enters a frame only on a new ss_n falling edge; if ss_n is still low, it waits for ss_n high then low.

Test Plan:
1. Mode 0, MSB first, DATAWIDTH=8: load txData=0x3C, master sends 0xA5 at divider 5 -> rxData=0xA5, rxValid=1; master receives 0x3C; txReady returns to 1 at ss_n fall.
2. All four cpol/cpha modes, lsbFirst 0 and 1: 16 random words each, slave echoes the previous rx word via txWrite -> master reads word[n-1] (first read 0x00); no mismatch.
3. Empty buffer: no txWrite, frame sent 0x5A -> miso shifts 0x00; rxData=0x5A.
4. Overrun: two words 0x11, 0x22 without rxRead -> rxData=0x22, rxOverrun pulses exactly once, rxValid=1. Repeat with rxRead on the completion cycle of 0x22 -> no pulse.
5. Abort: ss_n deasserted after 5 bits of 0xFF -> rxValid stays 0, misoEnable=0. Next full frame 0x81 -> rxData=0x81.
6. reset asserted mid-word with ss_n held low -> all outputs at reset values. No rx until ss_n toggles; the following frame of 0xC3 is received correctly.
